// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
//   Shared types and helpers for the round-robin stream multiplexer family.
//   - mux_mode_e : channel selection mode (explicit select or round-robin)
//   - idx_w()    : width of a binary channel index for an n-channel block
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // A single-channel block still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first requesting
//   channel found when searching ptr+1, ptr+2, ... modulo N, so the channel
//   at ptr has the lowest priority. With ptr = N-1 the search starts at 0.
//
// Ports
//   req      in   N    per-channel request
//   ptr      in   SW   index of the most recently granted channel
//   gnt      out  N    one-hot grant, zero when nothing requests
//   gnt_idx  out  SW   binary index of the granted channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx
);

    logic          found;
    logic [SW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = SW'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N-to-1 streaming multiplexer with a single registered valid/ready output.
//   The source channel is chosen either by an explicit select (mode = 0) or by
//   round-robin arbitration (mode = 1). The output register refills in the
//   same cycle it drains, so throughput is one beat per cycle.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   mode       in   1        0 = fixed select, 1 = round-robin
//   sel        in   SW       channel index used in fixed-select mode
//   in_valid   in   N        per-channel valid
//   in_data    in   N*WIDTH  packed data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  N        per-channel ready, one-hot or zero
//   out_valid  out  1        output register holds a beat
//   out_data   out  WIDTH    registered data
//   out_ch     out  SW       source channel of out_data
//   out_ready  in   1        downstream accepts
// -----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SW    = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_ch,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] ch_data [N];
    logic [SW-1:0]    ptr;
    logic             rr_mode;
    logic [N-1:0]     rr_gnt;
    logic [SW-1:0]    rr_idx;
    logic [N-1:0]     fix_gnt;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign rr_mode = (mux_mode_e'(mode) == MODE_RR);

    // ---- grant stage (combinational) ----------------------------------------
    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // An out-of-range select (possible when N is not a power of two) grants
    // nothing rather than aliasing onto a real channel.
    always_comb begin
        fix_gnt = '0;
        if ((int'(sel) < N) && in_valid[sel]) begin
            fix_gnt[sel] = 1'b1;
        end
    end

    assign grant     = rr_mode ? rr_gnt : fix_gnt;
    assign grant_idx = rr_mode ? rr_idx : sel;

    // The register can take a beat when empty or draining this cycle.
    // Gating with rst_n keeps every in_ready low while reset is held, even
    // though the cleared register would otherwise report itself loadable.
    assign load     = (!out_valid || out_ready) && rst_n;
    assign in_ready = grant & {N{load}};
    assign xfer     = |in_ready;

    assign grant_data = ch_data[grant_idx];

    // ---- output register stage ----------------------------------------------
    // ptr only moves on round-robin transfers, so fixed-select traffic leaves
    // the rotation exactly where it was when round-robin resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N - 1);
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (rr_mode) begin
                    ptr <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
